// File: rtl/qam_symbol_buffer_ctrl.sv
// Symbol FIFO plus frame-handshake FSM for the hard-decision QAM demapper output path.
// Buffers demapped symbols, announces full frames to the host and serves reads.
module qam_symbol_buffer_ctrl #(
    parameter int SYM_W     = 4,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic                     dclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode_stream,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_data,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [SYM_W-1:0]         rd_data,
    output logic                     available,
    output logic                     complete,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         overflow_cnt,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("qam_symbol_buffer_ctrl: DEPTH must be a power of 2 and at least 2");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > DEPTH) begin : g_bad_frame
        $error("qam_symbol_buffer_ctrl: FRAME_LEN must be in 1..DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        READY   = 2'b10,
        READOUT = 2'b11
    } fsm_t;

    fsm_t             fsm;
    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             has_space;
    logic             wr_en;
    logic             rd_en;
    logic             drop;
    logic [LW-1:0]    level_next;

    assign state = fsm;

    // Once a frame is announced, writes continue only in stream mode; a full FIFO always drops.
    always_comb begin
        has_space  = level < LW'(DEPTH);
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        drop       = 1'b0;
        if (enable) begin
            case (fsm)
                RECEIVE: begin
                    wr_en = sym_valid && has_space;
                    drop  = sym_valid && !has_space;
                end
                READY, READOUT: begin
                    wr_en = sym_valid && mode_stream && has_space;
                    drop  = sym_valid && !wr_en;
                    rd_en = (fsm == READOUT) && rd_req && (level != '0);
                end
                default: ;
            endcase
        end
        level_next = level + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge dclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sym_data;
        end
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            fsm          <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            available    <= 1'b0;
            complete     <= 1'b1;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            overflow_cnt <= '0;
        end else if (!enable) begin
            fsm       <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            available <= 1'b0;
            complete  <= 1'b1;
            rd_valid  <= 1'b0;
        end else begin
            level    <= level_next;
            rd_valid <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            if (drop && overflow_cnt != '1) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            case (fsm)
                IDLE: fsm <= RECEIVE;
                RECEIVE: begin
                    if (level_next >= LW'(FRAME_LEN)) begin
                        fsm       <= READY;
                        available <= 1'b1;
                        complete  <= 1'b0;
                    end
                end
                READY: begin
                    if (rd_req) begin
                        fsm <= READOUT;
                    end
                end
                READOUT: begin
                    if (rd_en && level_next == '0) begin
                        fsm       <= RECEIVE;
                        available <= 1'b0;
                        complete  <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
